// File: rtl/breath_pkg.sv
// ============================================================================
// Module      : breath_pkg
// Description : Shared state type and default sizing for the breathing-LED
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package breath_pkg;

    localparam int unsigned DEFAULT_PWM_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RISE    = 3'd1,
        ST_HOLD_HI = 3'd2,
        ST_FALL    = 3'd3,
        ST_HOLD_LO = 3'd4
    } breath_state_t;

endpackage

`default_nettype wire

// File: rtl/breath_pwm_core.sv
// ============================================================================
// Module      : pwm_core
// Description : Free-running PWM counter with a registered duty compare and
//               a period-end strobe for the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_core
    import breath_pkg::*;
#(
    parameter int unsigned PWM_W = DEFAULT_PWM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    output logic             led,
    output logic             period_end
);

    logic [PWM_W-1:0] pcnt_q;
    logic             led_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
            led_q  <= 1'b0;
        end else begin
            pcnt_q <= pcnt_q + PWM_W'(1);
            led_q  <= (duty > pcnt_q);
        end
    end

    assign period_end = (pcnt_q == {PWM_W{1'b1}});
    assign led        = led_q;

endmodule

`default_nettype wire

// File: rtl/breath_ctrl.sv
// ============================================================================
// Module      : breath_ctrl
// Description : Ramps PWM duty up/down on a step schedule; duty updates only
//               land on period boundaries. Macro BREATH_HOLD_EN adds dwell
//               states at peak and trough.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module breath_ctrl
    import breath_pkg::*;
#(
    parameter int unsigned PWM_W        = DEFAULT_PWM_W,
    parameter int unsigned STEP_PERIODS = 1024,
    parameter int unsigned HOLD_STEPS   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PWM_W-1:0] max_duty,
    output logic             led,
    output logic [PWM_W-1:0] duty,
    output logic             busy,
    output logic             cycle_done
);

    localparam int unsigned SCNT_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    breath_state_t     state_q, state_d;
    logic [PWM_W-1:0]  duty_q, duty_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic              cdone_q, cdone_d;
    logic              period_end;
    logic              step_tick;
    logic [PWM_W:0]    duty_inc;

    pwm_core #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk        (clk),
        .rst        (rst),
        .duty       (duty_q),
        .led        (led),
        .period_end (period_end)
    );

    assign step_tick = period_end && (scnt_q == SCNT_W'(STEP_PERIODS - 1));
    assign duty_inc  = {1'b0, duty_q} + {{PWM_W{1'b0}}, 1'b1};

`ifdef BREATH_HOLD_EN
    localparam int unsigned HCNT_W = $clog2(HOLD_STEPS + 1);

    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic [HCNT_W:0]   hcnt_inc;
    logic              hold_done;

    assign hcnt_inc  = {1'b0, hcnt_q} + {{HCNT_W{1'b0}}, 1'b1};
    assign hold_done = (hcnt_inc >= (HCNT_W + 1)'(HOLD_STEPS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
        end
    end
`else
    // Dwell length is meaningless without the hold states.
    if (HOLD_STEPS == 0) begin : g_hold_unused
    end
`endif

    always_comb begin
        scnt_d = scnt_q;
        if (state_q == ST_IDLE) begin
            scnt_d = '0;
        end else if (period_end) begin
            scnt_d = step_tick ? '0 : scnt_q + SCNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        cdone_d = 1'b0;
`ifdef BREATH_HOLD_EN
        hcnt_d  = hcnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                duty_d = '0;
                if (en) begin
                    state_d = ST_RISE;
                end
            end
            ST_RISE: begin
                if (step_tick) begin
                    if (!en) begin
                        state_d = ST_FALL;
                    end else if ({1'b0, max_duty} <= duty_inc) begin
                        // Also covers a peak lowered below the current duty.
                        duty_d = max_duty;
`ifdef BREATH_HOLD_EN
                        state_d = ST_HOLD_HI;
                        hcnt_d  = '0;
`else
                        state_d = ST_FALL;
`endif
                    end else begin
                        duty_d = duty_q + PWM_W'(1);
                    end
                end
            end
`ifdef BREATH_HOLD_EN
            ST_HOLD_HI: begin
                if (step_tick) begin
                    if (!en || hold_done) begin
                        state_d = ST_FALL;
                    end else begin
                        hcnt_d = hcnt_inc[HCNT_W-1:0];
                    end
                end
            end
            ST_HOLD_LO: begin
                if (step_tick) begin
                    if (!en) begin
                        state_d = ST_IDLE;
                    end else if (hold_done) begin
                        state_d = ST_RISE;
                    end else begin
                        hcnt_d = hcnt_inc[HCNT_W-1:0];
                    end
                end
            end
`endif
            ST_FALL: begin
                if (step_tick) begin
                    if (duty_q > PWM_W'(1)) begin
                        duty_d = duty_q - PWM_W'(1);
                    end else begin
                        duty_d  = '0;
                        cdone_d = 1'b1;
`ifdef BREATH_HOLD_EN
                        state_d = en ? ST_HOLD_LO : ST_IDLE;
                        hcnt_d  = '0;
`else
                        state_d = en ? ST_RISE : ST_IDLE;
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                duty_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            scnt_q  <= '0;
            cdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            scnt_q  <= scnt_d;
            cdone_q <= cdone_d;
        end
    end

    assign duty       = duty_q;
    assign busy       = (state_q != ST_IDLE);
    assign cycle_done = cdone_q;

endmodule

`default_nettype wire

// File: tb/tb_breath_ctrl.sv
// ============================================================================
// Module      : tb_breath_ctrl
// Description : Directed self-checking bench for breath_ctrl (PWM_W=4,
//               STEP_PERIODS=2, HOLD_STEPS=1); adapts to BREATH_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_breath_ctrl;

`ifdef BREATH_HOLD_EN
    localparam int GAP  = 64;   // clocks between peak and first fall step
    localparam int ZINT = 128;  // breath length with max_duty=0
`else
    localparam int GAP  = 32;
    localparam int ZINT = 64;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [3:0] max_duty = 4'd0;
    logic       led;
    logic [3:0] duty;
    logic       busy;
    logic       cycle_done;

    int n_pass  = 0;
    int n_total = 0;

    breath_ctrl #(
        .PWM_W        (4),
        .STEP_PERIODS (2),
        .HOLD_STEPS   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .max_duty   (max_duty),
        .led        (led),
        .duty       (duty),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_change(input int budget, output logic [3:0] val,
                               output int dt, output bit to);
        logic [3:0] prev;
        prev = duty;
        val  = duty;
        dt   = 0;
        to   = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            dt++;
            if (duty !== prev) begin
                to  = 1'b0;
                val = duty;
                break;
            end
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        max_duty = 4'd0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (duty !== 4'd0) $display("FAIL reset_duty got %0d want 0", duty); else n_pass++;
        n_total++; if (led !== 1'b0) $display("FAIL reset_led got %b want 0", led); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
        n_total++; if (cycle_done !== 1'b0) $display("FAIL reset_cdone got %b want 0", cycle_done); else n_pass++;
        repeat (40) tick();
        n_total++; if (busy !== 1'b0 || duty !== 4'd0) $display("FAIL idle_stays busy=%b duty=%0d want 0/0", busy, duty); else n_pass++;
    endtask

    task automatic test_ramp();
        logic [3:0] exp_v [8] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
        int         exp_dt[8] = '{0, 32, 32, 32, GAP - 16, 32, 32, 32};
        logic [3:0]  v;
        logic [15:0] pat;
        int dt;
        bit to;
        max_duty = 4'd4;
        en = 1'b1;
        tick();
        n_total++; if (busy !== 1'b1) $display("FAIL en_to_busy got %b want 1", busy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            wait_change(200, v, dt, to);
            n_total++;
            if (to || v !== exp_v[i]) $display("FAIL ramp_val[%0d] got %0d (timeout=%0d) want %0d", i, v, to, exp_v[i]);
            else n_pass++;
            if (i > 0) begin
                n_total++;
                if (dt !== exp_dt[i]) $display("FAIL ramp_interval[%0d] got %0d want %0d", i, dt, exp_dt[i]);
                else n_pass++;
            end
            if (i == 3) begin
                n_total++; if (cycle_done !== 1'b0) $display("FAIL cdone_at_peak got %b want 0", cycle_done); else n_pass++;
                for (int k = 0; k < 16; k++) begin
                    tick();
                    pat[k] = led;
                end
                n_total++; if (pat !== 16'h000F) $display("FAIL led_pattern got %h want 000f", pat); else n_pass++;
            end
        end
        n_total++; if (cycle_done !== 1'b1) $display("FAIL cdone_pulse got %b want 1", cycle_done); else n_pass++;
        tick();
        n_total++; if (cycle_done !== 1'b0) $display("FAIL cdone_width got %b want 0", cycle_done); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL busy_after_breath got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_reset_midrun();
        logic [3:0] v;
        int dt;
        bit to;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd1) $display("FAIL rerise got %0d (timeout=%0d) want 1", v, to); else n_pass++;
        tick();
        n_total++; if (led !== 1'b1) $display("FAIL led_before_rst got %b want 1", led); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++;
        if (duty !== 4'd0 || led !== 1'b0 || busy !== 1'b0 || cycle_done !== 1'b0)
            $display("FAIL midrun_reset got duty=%0d led=%b busy=%b cdone=%b want all 0", duty, led, busy, cycle_done);
        else n_pass++;
        do_reset();
    endtask

    task automatic test_drop_en();
        logic [3:0] v;
        int dt;
        bit to;
        max_duty = 4'd4;
        en = 1'b1;
        wait_change(200, v, dt, to);
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd2) $display("FAIL drop_reach2 got %0d want 2", v); else n_pass++;
        en = 1'b0;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd1 || dt !== 64) $display("FAIL drop_first_fall got %0d dt=%0d want 1 dt=64", v, dt); else n_pass++;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd0 || dt !== 32) $display("FAIL drop_zero got %0d dt=%0d want 0 dt=32", v, dt); else n_pass++;
        n_total++; if (cycle_done !== 1'b1) $display("FAIL drop_cdone got %b want 1", cycle_done); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL drop_idle_busy got %b want 0", busy); else n_pass++;
        wait_change(80, v, dt, to);
        n_total++; if (!to || busy !== 1'b0) $display("FAIL drop_stays_idle duty=%0d busy=%b want 0/0", v, busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        int dt;
        bit to;
        max_duty = 4'd4;
        en = 1'b1;
        wait_change(200, v, dt, to);
        wait_change(200, v, dt, to);
        en = 1'b0;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd1) $display("FAIL b2b_fall got %0d want 1", v); else n_pass++;
        en = 1'b1;
        wait_change(200, v, dt, to);
        n_total++;
        if (to || v !== 4'd0 || busy !== 1'b1 || cycle_done !== 1'b1)
            $display("FAIL b2b_end got duty=%0d busy=%b cdone=%b want 0/1/1", v, busy, cycle_done);
        else n_pass++;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd1 || dt !== GAP) $display("FAIL b2b_rerise got %0d dt=%0d want 1 dt=%0d", v, dt, GAP); else n_pass++;
        do_reset();
    endtask

    task automatic test_max_zero();
        int p0 = -1;
        int p1 = -1;
        int width = 0;
        int run = 0;
        bit seen_hi = 1'b0;
        max_duty = 4'd0;
        en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (led !== 1'b0 || duty !== 4'd0) seen_hi = 1'b1;
            if (cycle_done === 1'b1) begin
                run++;
                if (run > width) width = run;
                if (run == 1) begin
                    if (p0 < 0) p0 = i;
                    else if (p1 < 0) p1 = i;
                end
            end else begin
                run = 0;
            end
        end
        n_total++; if (p0 < 0 || p1 < 0) $display("FAIL zero_pulses got p0=%0d p1=%0d want two pulses", p0, p1); else n_pass++;
        n_total++; if (p1 - p0 !== ZINT) $display("FAIL zero_interval got %0d want %0d", p1 - p0, ZINT); else n_pass++;
        n_total++; if (width !== 1) $display("FAIL zero_width got %0d want 1", width); else n_pass++;
        n_total++; if (seen_hi !== 1'b0) $display("FAIL zero_led got %b want 0", seen_hi); else n_pass++;
        do_reset();
    endtask

    task automatic test_lower_max();
        logic [3:0] v;
        int dt;
        bit to;
        max_duty = 4'd12;
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wait_change(200, v, dt, to);
        end
        n_total++; if (to || v !== 4'd6) $display("FAIL lower_reach6 got %0d want 6", v); else n_pass++;
        max_duty = 4'd3;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd3 || dt !== 32) $display("FAIL lower_clamp got %0d dt=%0d want 3 dt=32", v, dt); else n_pass++;
        wait_change(200, v, dt, to);
        n_total++; if (to || v !== 4'd2 || dt !== GAP) $display("FAIL lower_fall got %0d dt=%0d want 2 dt=%0d", v, dt, GAP); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reset_midrun();
        test_drop_en();
        test_back_to_back();
        test_max_zero();
        test_lower_max();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
